// File: rtl/console_pkg.sv
// Shared console types: character width, message length limit, arbiter FSM states.
// Pure declarations; no logic, no latency, no flow control.
// Imported by the console arbiter and the multi-sink schedulers.
package console_pkg;

    localparam int CHAR_W        = 8;
    localparam int MSG_MAX_CHARS = 100;

    typedef enum logic {IDLE, BUSY} state_t;

    typedef logic [CHAR_W-1:0] char_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request at or after rr_ptr, searching cyclically.
// Combinational, zero latency.
// No flow control; grant is only meaningful while any_valid is high.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int SRC_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   rr_ptr,
    output logic [SRC_W-1:0]   grant,
    output logic               any_valid
);

    int               idx;
    logic [SRC_W-1:0] idx_s;

    // Walk offsets from farthest to nearest so the closest requester wins.
    always_comb begin
        grant = rr_ptr;
        idx   = 0;
        idx_s = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_s = SRC_W'(idx);
            if (req[idx_s]) begin
                grant = idx_s;
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/console_arbiter.sv
// Message-granular round-robin arbiter from NUM_REQ character sources to one sink.
// Latency: 1 cycle arbitration, then 1 cycle from accept to out_valid.
// Backpressure: a stalled output register drops req_ready; grants end on last, MAX_LEN or TIMEOUT.
module console_arbiter
    import console_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    parameter int  MAX_LEN = MSG_MAX_CHARS,
    parameter int  TIMEOUT = 16,
    localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [CHAR_W*NUM_REQ-1:0] req_char,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [CHAR_W-1:0]         out_char,
    output logic                      out_last,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      trunc_err,
    output logic                      timeout_err
);

    localparam int CNT_W  = $clog2(MAX_LEN + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    state_t             state;
    logic [SRC_W-1:0]   gnt;
    logic [SRC_W-1:0]   gnt_next;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   pick;
    logic               any_valid;
    logic [CNT_W-1:0]   char_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               slot_free;
    logic               accept;
    logic               cut;
    logic               g_valid;
    logic               g_last;
    char_t              g_char;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_rr_picker (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick),
        .any_valid (any_valid)
    );

    always_comb begin
        g_char = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (SRC_W'(i) == gnt) begin
                g_char = req_char[CHAR_W*i +: CHAR_W];
            end
        end
    end

    assign g_valid   = req_valid[gnt];
    assign g_last    = req_last[gnt];
    assign slot_free = !out_valid || out_ready;
    assign accept    = (state == BUSY) && g_valid && slot_free;
    assign cut       = (char_cnt == CNT_W'(MAX_LEN - 1));
    assign gnt_next  = (gnt == SRC_W'(NUM_REQ - 1)) ? '0 : gnt + SRC_W'(1);
    assign busy      = (state == BUSY);

    always_comb begin
        req_ready = '0;
        if (state == BUSY) begin
            req_ready[gnt] = slot_free;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            gnt         <= '0;
            rr_ptr      <= '0;
            char_cnt    <= '0;
            idle_cnt    <= '0;
            out_valid   <= 1'b0;
            out_char    <= '0;
            out_last    <= 1'b0;
            out_src     <= '0;
            trunc_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            trunc_err   <= 1'b0;
            timeout_err <= 1'b0;

            // A drain without a fresh load empties the slot; other fields hold.
            if (accept) begin
                out_valid <= 1'b1;
                out_char  <= g_char;
                out_src   <= gnt;
                out_last  <= g_last || cut;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (any_valid) begin
                        gnt      <= pick;
                        char_cnt <= '0;
                        idle_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    idle_cnt <= g_valid ? '0 : idle_cnt + IDLE_W'(1);
                    if (accept) begin
                        char_cnt  <= char_cnt + CNT_W'(1);
                        trunc_err <= cut && !g_last;
                        if (g_last || cut) begin
                            state  <= IDLE;
                            rr_ptr <= gnt_next;
                        end
                    end else if (!g_valid && idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                        state       <= IDLE;
                        rr_ptr      <= gnt_next;
                        timeout_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
